// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: hazard inputs from the Y86-64 stages and the
// stall/bubble/status outputs returned to them.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       E_icode;
    logic [3:0]       M_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc;
    logic             halted;
    logic [3:0]       halt_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // The pipeline datapath drives the hazard inputs and consumes the controls.
    modport master (
        output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd,
               m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, halt_stat, cyc_cnt, stall_cnt, mispred_cnt
    );

    modport slave (
        input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd,
               m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, halt_stat, cyc_cnt, stall_cnt, mispred_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection, stall/bubble generation,
// halt latching and saturating performance counters.
module pipe_ctrl #(
    parameter int         CNT_W = 32,
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave bus
);
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_HLT    = 4'h2;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] S_INS    = 4'h4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t           state, next_state;
    logic [3:0]       halt_stat_q;
    logic [CNT_W-1:0] cyc_q, stall_q, mispred_q;
    logic             lu, rt, mp, exc_m, exc_w;

    assign lu = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                (bus.E_dstM != RNONE) &&
                ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign rt = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                (bus.M_icode == I_RET);
    assign mp = (bus.E_icode == I_JXX) && !bus.e_Cnd;
    assign exc_m = (bus.m_stat == S_HLT) || (bus.m_stat == S_ADR) ||
                   (bus.m_stat == S_INS);
    assign exc_w = (bus.W_stat == S_HLT) || (bus.W_stat == S_ADR) ||
                   (bus.W_stat == S_INS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= next_state;
    end

    // Once halted, everything upstream is frozen and the W register holds
    // the faulting instruction so its status stays observable.
    always_comb begin
        next_state   = state;
        bus.F_stall  = 1'b0;
        bus.D_stall  = 1'b0;
        bus.D_bubble = 1'b0;
        bus.E_bubble = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_stall  = 1'b0;
        bus.set_cc   = 1'b0;
        case (state)
            RUN: begin
                bus.F_stall  = lu | rt;
                bus.D_stall  = lu;
                bus.D_bubble = mp | (rt & ~lu);
                bus.E_bubble = mp | lu;
                bus.M_bubble = exc_m | exc_w;
                bus.W_stall  = exc_w;
                bus.set_cc   = (bus.E_icode == I_OPQ) & ~exc_m & ~exc_w;
                if (exc_w) next_state = HALTED;
            end
            HALTED: begin
                bus.F_stall  = 1'b1;
                bus.D_stall  = 1'b1;
                bus.M_bubble = 1'b1;
                bus.W_stall  = 1'b1;
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   halt_stat_q <= S_AOK;
        else if (state == RUN && exc_w) halt_stat_q <= bus.W_stat;
    end

    // Counters only advance while running and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= '0;
            stall_q   <= '0;
            mispred_q <= '0;
        end else if (state == RUN) begin
            if (cyc_q != CNT_MAX)                 cyc_q     <= cyc_q + CNT_W'(1);
            if ((lu | rt) && stall_q != CNT_MAX)  stall_q   <= stall_q + CNT_W'(1);
            if (mp && mispred_q != CNT_MAX)       mispred_q <= mispred_q + CNT_W'(1);
        end
    end

    assign bus.halted      = (state == HALTED);
    assign bus.halt_stat   = halt_stat_q;
    assign bus.cyc_cnt     = cyc_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.mispred_cnt = mispred_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios checked against
// a behavioural model every cycle, plus hand-computed literal expectations.
module tb_pipe_ctrl;
    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic rst_n_sat = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    pipe_ctrl_if #(.CNT_W(32)) pif ();
    pipe_ctrl_if #(.CNT_W(4))  sif ();

    pipe_ctrl #(.CNT_W(32), .RNONE(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(pif));
    pipe_ctrl #(.CNT_W(4),  .RNONE(4'hF)) sat (.clk(clk), .rst_n(rst_n_sat), .bus(sif));

    always #5 clk = ~clk;

    function automatic logic is_exc(input logic [3:0] s);
        return (s inside {4'h2, 4'h3, 4'h4});
    endfunction

    // Returns {lu, rt, mp} from the hazard rules.
    function automatic logic [2:0] hazards(input logic [3:0] d, e, m, sa, sb, dm,
                                           input logic cnd);
        logic is_load, reads;
        is_load = (e == 4'h5) || (e == 4'hB);
        reads   = (dm == sa) || (dm == sb);
        return {is_load && dm != 4'hF && reads,
                (d == 4'h9) || (e == 4'h9) || (m == 4'h9),
                e == 4'h7 && cnd == 1'b0};
    endfunction

    // Returns {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}.
    function automatic logic [6:0] exp_ctrl(input logic hlt, input logic [2:0] h,
                                            input logic [3:0] e, ms, ws);
        logic lu, rt, mp;
        {lu, rt, mp} = h;
        if (hlt) return 7'b1100110;
        return {lu || rt, lu, mp || (rt && !lu), mp || lu,
                is_exc(ms) || is_exc(ws), is_exc(ws),
                e == 4'h6 && !is_exc(ms) && !is_exc(ws)};
    endfunction

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state for the 32-bit instance and the 4-bit saturation instance.
    logic       m_halted = 1'b0, s_halted = 1'b0;
    logic [3:0] m_hstat  = 4'h1, s_hstat  = 4'h1;
    longint     m_cyc = 0, m_stall = 0, m_mp = 0;
    longint     s_cyc = 0, s_stall = 0, s_mp = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [2:0] h;
        if (!rst_n) begin
            m_halted <= 1'b0; m_hstat <= 4'h1;
            m_cyc <= 0; m_stall <= 0; m_mp <= 0;
        end else if (!m_halted) begin
            h = hazards(pif.D_icode, pif.E_icode, pif.M_icode, pif.d_srcA,
                        pif.d_srcB, pif.E_dstM, pif.e_Cnd);
            m_cyc <= sat_inc(m_cyc, 64'hFFFF_FFFF);
            if (h[2] || h[1]) m_stall <= sat_inc(m_stall, 64'hFFFF_FFFF);
            if (h[0])         m_mp    <= sat_inc(m_mp, 64'hFFFF_FFFF);
            if (is_exc(pif.W_stat)) begin
                m_halted <= 1'b1;
                m_hstat  <= pif.W_stat;
            end
        end
    end

    always @(posedge clk or negedge rst_n_sat) begin
        logic [2:0] h;
        if (!rst_n_sat) begin
            s_halted <= 1'b0; s_hstat <= 4'h1;
            s_cyc <= 0; s_stall <= 0; s_mp <= 0;
        end else if (!s_halted) begin
            h = hazards(sif.D_icode, sif.E_icode, sif.M_icode, sif.d_srcA,
                        sif.d_srcB, sif.E_dstM, sif.e_Cnd);
            s_cyc <= sat_inc(s_cyc, 15);
            if (h[2] || h[1]) s_stall <= sat_inc(s_stall, 15);
            if (h[0])         s_mp    <= sat_inc(s_mp, 15);
            if (is_exc(sif.W_stat)) begin
                s_halted <= 1'b1;
                s_hstat  <= sif.W_stat;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] h;
        logic [6:0] e;
        h = hazards(pif.D_icode, pif.E_icode, pif.M_icode, pif.d_srcA,
                    pif.d_srcB, pif.E_dstM, pif.e_Cnd);
        if (h[2] && h[0]) $display("[TB] illegal input: load/use and mispredict together");
        e = exp_ctrl(m_halted, h, pif.E_icode, pif.m_stat, pif.W_stat);
        checkOutput("cmp F_stall",   pif.F_stall,   e[6]);
        checkOutput("cmp D_stall",   pif.D_stall,   e[5]);
        checkOutput("cmp D_bubble",  pif.D_bubble,  e[4]);
        checkOutput("cmp E_bubble",  pif.E_bubble,  e[3]);
        checkOutput("cmp M_bubble",  pif.M_bubble,  e[2]);
        checkOutput("cmp W_stall",   pif.W_stall,   e[1]);
        checkOutput("cmp set_cc",    pif.set_cc,    e[0]);
        checkOutput("cmp halted",    pif.halted,    m_halted);
        checkOutput("cmp halt_stat", pif.halt_stat, m_hstat);
        checkOutput("cmp cyc_cnt",   pif.cyc_cnt,   m_cyc);
        checkOutput("cmp stall_cnt", pif.stall_cnt, m_stall);
        checkOutput("cmp mispred",   pif.mispred_cnt, m_mp);
        h = hazards(sif.D_icode, sif.E_icode, sif.M_icode, sif.d_srcA,
                    sif.d_srcB, sif.E_dstM, sif.e_Cnd);
        e = exp_ctrl(s_halted, h, sif.E_icode, sif.m_stat, sif.W_stat);
        checkOutput("sat ctrl",      {sif.F_stall, sif.D_stall, sif.D_bubble, sif.E_bubble,
                                      sif.M_bubble, sif.W_stall, sif.set_cc}, e);
        checkOutput("sat cyc_cnt",   sif.cyc_cnt,     s_cyc);
        checkOutput("sat stall_cnt", sif.stall_cnt,   s_stall);
        checkOutput("sat mispred",   sif.mispred_cnt, s_mp);
    end

    task automatic applyStimulus(input logic [3:0] d, e, m, sa, sb, dm,
                                 input logic cnd, input logic [3:0] ms, ws);
        pif.D_icode = d;  pif.E_icode = e;  pif.M_icode = m;
        pif.d_srcA  = sa; pif.d_srcB  = sb; pif.E_dstM  = dm;
        pif.e_Cnd   = cnd; pif.m_stat = ms; pif.W_stat  = ws;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // The saturation instance mispredicts every running cycle.
        sif.D_icode = 4'h1; sif.E_icode = 4'h7; sif.M_icode = 4'h1;
        sif.d_srcA = 4'hF; sif.d_srcB = 4'hF; sif.E_dstM = 4'hF;
        sif.e_Cnd = 1'b0; sif.m_stat = 4'h1; sif.W_stat = 4'h1;
        applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);

        step(2);
        checkOutput("reset halted",    pif.halted, 0);
        checkOutput("reset halt_stat", pif.halt_stat, 1);
        checkOutput("reset cyc_cnt",   pif.cyc_cnt, 0);
        rst_n = 1'b1; rst_n_sat = 1'b1;
        step(1);
        checkOutput("first cyc_cnt", pif.cyc_cnt, 1);

        applyStimulus(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h1, 4'h1);
        #1;
        checkOutput("lu F_stall", pif.F_stall, 1);
        checkOutput("lu D_stall", pif.D_stall, 1);
        checkOutput("lu E_bubble", pif.E_bubble, 1);
        checkOutput("lu D_bubble", pif.D_bubble, 0);
        step(3);
        checkOutput("lu stall_cnt", pif.stall_cnt, 3);

        applyStimulus(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
        #1;
        checkOutput("ret F_stall", pif.F_stall, 1);
        checkOutput("ret D_bubble", pif.D_bubble, 1);
        checkOutput("ret D_stall", pif.D_stall, 0);
        step(1);
        applyStimulus(4'h1, 4'h5, 4'h9, 4'hF, 4'h2, 4'h2, 1'b1, 4'h1, 4'h1);
        #1;
        checkOutput("ret+lu D_bubble", pif.D_bubble, 0);
        checkOutput("ret+lu D_stall", pif.D_stall, 1);
        step(1);

        applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1);
        #1;
        checkOutput("mp D_bubble", pif.D_bubble, 1);
        checkOutput("mp E_bubble", pif.E_bubble, 1);
        checkOutput("mp F_stall", pif.F_stall, 0);
        checkOutput("mp cnt before", pif.mispred_cnt, 0);
        step(1);
        checkOutput("mp cnt after", pif.mispred_cnt, 1);
        applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
        #1;
        checkOutput("taken ctrl", {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble}, 0);
        step(1);

        applyStimulus(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1);
        #1;
        checkOutput("opq set_cc", pif.set_cc, 1);
        applyStimulus(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h3, 4'h1);
        #1;
        checkOutput("adr set_cc", pif.set_cc, 0);
        checkOutput("adr M_bubble", pif.M_bubble, 1);
        step(1);
        checkOutput("running cyc_cnt", pif.cyc_cnt, 9);
        checkOutput("running stall_cnt", pif.stall_cnt, 5);

        applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h2);
        #1;
        checkOutput("hlt W_stall", pif.W_stall, 1);
        checkOutput("hlt not yet halted", pif.halted, 0);
        step(1);
        checkOutput("halted", pif.halted, 1);
        checkOutput("halt_stat", pif.halt_stat, 2);
        checkOutput("halt cyc_cnt", pif.cyc_cnt, 10);
        applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1);
        step(3);
        checkOutput("stay halted", pif.halted, 1);
        checkOutput("frozen cyc_cnt", pif.cyc_cnt, 10);
        checkOutput("frozen stall_cnt", pif.stall_cnt, 5);
        checkOutput("frozen mispred", pif.mispred_cnt, 1);
        checkOutput("halted ctrl", {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble,
                                    pif.M_bubble, pif.W_stall, pif.set_cc}, 7'b1100110);

        #1 rst_n = 1'b0;
        #1;
        checkOutput("async halted", pif.halted, 0);
        checkOutput("async cyc_cnt", pif.cyc_cnt, 0);
        checkOutput("async halt_stat", pif.halt_stat, 1);
        checkOutput("async D_bubble", pif.D_bubble, 1);
        rst_n = 1'b1;
        applyStimulus(4'h1, 4'hB, 4'h1, 4'hF, 4'h4, 4'hF, 1'b1, 4'h1, 4'h1);
        #1;
        checkOutput("rnone F_stall", pif.F_stall, 0);
        checkOutput("rnone D_stall", pif.D_stall, 0);
        step(1);
        checkOutput("restart cyc_cnt", pif.cyc_cnt, 1);

        step(20);
        checkOutput("sat cyc 15", sif.cyc_cnt, 15);
        checkOutput("sat mp 15", sif.mispred_cnt, 15);
        checkOutput("sat stall 0", sif.stall_cnt, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
